// File: rtl/serial_subtractor_64_pkg.sv
// Shared definitions for the slice-serial subtractor: FSM states, default
// geometry and the index-width helper.
package serial_subtractor_64_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_SLICE   = 8;
  localparam int SLICE_COUNT = DEF_WIDTH / DEF_SLICE;

  // Width of a counter that walks slices 0..n-1; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_64_slice.sv
// One SLICE-bit subtract step: d = x + ~y + cin, shared by every cycle of an
// operation.
module byte_subtract_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] d,
  output logic             cout
);

  logic [SLICE:0] sum;

  assign sum  = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, cin};
  assign d    = sum[SLICE-1:0];
  assign cout = sum[SLICE];

endmodule

// File: rtl/serial_subtractor_64.sv
// 64-bit subtractor computing a - b one slice per clock, LSB slice first,
// behind a start/busy/done handshake.
module serial_subtractor_64
  import serial_subtractor_64_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  sub_state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             accept;
  logic             step;
  logic             last;

  logic [SLICE-1:0] s_x;
  logic [SLICE-1:0] s_y;
  logic [SLICE-1:0] s_d;
  logic             s_cout;

  assign last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A start seen while done is high chains straight into the next run.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_x = a_q[idx_q*SLICE +: SLICE];
  assign s_y = b_q[idx_q*SLICE +: SLICE];

  byte_subtract_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .x    (s_x),
    .y    (s_y),
    .cin  (carry_q),
    .d    (s_d),
    .cout (s_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      diff_q  <= '0;
      carry_q <= 1'b1;
      idx_q   <= '0;
    end else if (step) begin
      diff_q[idx_q*SLICE +: SLICE] <= s_d;
      carry_q <= s_cout;
      if (last) begin
        // s_d[SLICE-1] is the result MSB being written on this same edge.
        borrow_q <= ~s_cout;
        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_d[SLICE-1] != a_q[WIDTH-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule
